seg7_display: RTL and testbench
===============================

SEG7_DISPLAY -- requirements
Module: seg7_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 20000: clk cycles each digit is displayed; legal values >= 2.
REQ-002 SHALL have parameter BLINK_DIV, default 64: number of full 8-digit scan frames per blink half-period; used only under SEG7_BLINK_EN.
REQ-003 SHALL have port clk, input, 1 bit: single clock, the CPU clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port seg_write, input, 1 bit: IO write strobe from the CPU.
REQ-006 SHALL have port seg_cs, input, 1 bit: chip select from the memory/IO address decoder.
REQ-007 SHALL have port seg_addr, input, 2 bits: register select (address bits [1:0]).
REQ-008 SHALL have port seg_wdata, input, 16 bits: write data.
REQ-009 SHALL have port seg_an, output, 8 bits: digit anodes, active low, bit n = digit n.
REQ-010 SHALL have port seg_out, output, 8 bits: segment cathodes, active low, order {dp,g,f,e,d,c,b,a}.

Function
REQ-011 SHALL write a register on a rising clk edge only when seg_cs=1 and seg_write=1; all other cycles leave registers unchanged.
REQ-012 SHALL map seg_addr as follows: 0 -> DATA_LO (digits 3..0, 4 bits each); 1 -> DATA_HI (digits 7..4); 2 -> CTRL, where [7:0] is the digit enable mask and [15:8] is the decimal-point mask; 3 -> BLINK mask [7:0] under SEG7_BLINK_EN, otherwise the write is ignored.
REQ-013 SHALL keep a divider counting 0..SCAN_DIV-1; on reaching SCAN_DIV-1 it returns to 0 and the digit index increments.
REQ-014 SHALL wrap the digit index from 7 to 0, with no idle slot.
REQ-015 SHALL register seg_an and seg_out, so they reflect the digit index, data and masks with exactly 1 cycle of latency.
REQ-016 SHALL drive the selected digit's anode low and all other anodes high when the selected digit is enabled.
REQ-017 SHALL drive seg_an=8'hFF and seg_out=8'hFF for a disabled digit, which still consumes its full time slot so brightness stays constant.
REQ-018 SHALL decode each nibble as hexadecimal 0-F using the standard glyphs: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (dp bit high).
REQ-019 SHALL drive seg_out[7] low when the dp mask bit of the current digit is 1.
REQ-020 SHALL apply both events when a register write and a digit advance occur in the same cycle; the next displayed output uses the new index with the new data.

Reset
REQ-021 SHALL, while rst=1, force seg_an=8'hFF, seg_out=8'hFF, DATA_LO=DATA_HI=0, enable mask=8'hFF, dp mask=8'h00, BLINK=8'h00, divider=0, digit index=0 and blink state=visible.
REQ-022 SHALL take priority for rst over any simultaneous write; asserting rst mid-scan restarts at digit 0 on the first cycle after release.
REQ-023 SHALL show digit 0 on the first output registered after rst deasserts.

Configuration
REQ-024 SHALL support macro SEG7_BLINK_EN.
- Defined: a frame counter (one frame = 8 digit slots) toggles the blink state every BLINK_DIV frames, and digits whose BLINK bit is 1 are blanked (as REQ-017) during the hidden half.
- Undefined: no frame counter or blink register exists, addr 3 writes are ignored, and no digit ever blinks.

Verification (SCAN_DIV=4)
REQ-025 SHALL cover reset: rst=1 for 3 cycles -> seg_an=FF, seg_out=FF; one cycle after release -> seg_an=FE, seg_out=C0.
REQ-026 SHALL cover data write: write addr0=0x1234 -> digit0 slot shows seg_an=FE, seg_out=99; digit1 slot shows seg_an=FD, seg_out=B0.
REQ-027 SHALL cover scan wrap: free run for 32 cycles -> seg_an sequence FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles, then FE again.
REQ-028 SHALL cover the enable and dp masks:
- write addr2=0x0101 with DATA_LO=0x1234 -> digit0 shows seg_out=19;
- slots for digits 1-7 show seg_an=FF, seg_out=FF.
REQ-029 SHALL cover gated writes: seg_cs=0, seg_write=1, addr0=0xFFFF -> display unchanged. A write in the final divider cycle of digit0 -> digit1 slot immediately shows the new nibble.
REQ-030 SHALL cover blink, with SEG7_BLINK_EN and BLINK_DIV=1: write addr3=0x0001 -> digit0 alternates between visible and blank each 32-cycle frame; other digits are unaffected.

Source files
------------

// File: rtl/seg7_display_if.sv
// CPU-side register write bus for the 8-digit seven-segment display controller.
// Latency: none (wires only); the controller samples these on its clock edge.
// Backpressure: none; every qualified write is accepted in the cycle it is presented.
//
// Signals:
//   seg_write  IO write strobe from the CPU
//   seg_cs     chip select from the address decoder
//   seg_addr   register select (address bits [1:0])
//   seg_wdata  16-bit write data
// Modports: master (CPU / bench drives the bus), slave (display controller).
interface seg7_display_if;
    logic        seg_write;
    logic        seg_cs;
    logic [1:0]  seg_addr;
    logic [15:0] seg_wdata;

    modport master (
        output seg_write,
        output seg_cs,
        output seg_addr,
        output seg_wdata
    );

    modport slave (
        input seg_write,
        input seg_cs,
        input seg_addr,
        input seg_wdata
    );
endinterface

// File: rtl/seg7_display.sv
// Multiplexed 8-digit hex seven-segment driver with CPU-writable data, enable, dp and blink masks.
// Latency: seg_an/seg_out are registered, 1 clk behind the scan index, data and masks.
// Backpressure: none; register writes always land, the scan free-runs regardless of the bus.
//
// Ports:
//   clk      single rising-edge clock (CPU clock)
//   rst      synchronous active-high reset; blanks the display and restarts the scan at digit 0
//   bus      seg7_display_if.slave register write port (seg_write, seg_cs, seg_addr, seg_wdata)
//   seg_an   digit anodes, active low, bit n = digit n
//   seg_out  segment cathodes, active low, {dp,g,f,e,d,c,b,a}
//
// Register map (seg_addr):
//   0  DATA_LO  digits 3..0, one hex nibble each
//   1  DATA_HI  digits 7..4
//   2  CTRL     [7:0] digit enable mask, [15:8] decimal-point mask
//   3  BLINK    [7:0] blink mask (only when SEG7_BLINK_EN is defined, else ignored)
//
// Build option: define SEG7_BLINK_EN to add the frame counter and blink register.
module seg7_display #(
    parameter int SCAN_DIV  = 20000,
    parameter int BLINK_DIV = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_display_if.slave        bus,
    output logic [7:0]           seg_an,
    output logic [7:0]           seg_out
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("seg7_display: SCAN_DIV must be >= 2");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink_div
        $error("seg7_display: BLINK_DIV must be >= 1");
    end

    localparam int                 DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [15:0] data_hi;   // digits 7..4
        logic [15:0] data_lo;   // digits 3..0
        logic [7:0]  dp_mask;   // 1 = light the decimal point of that digit
        logic [7:0]  en_mask;   // 1 = digit is shown, 0 = digit blanked
    } regs_t;

    localparam regs_t REGS_RST = '{
        data_hi: 16'h0000,
        data_lo: 16'h0000,
        dp_mask: 8'h00,
        en_mask: 8'hFF
    };

    regs_t regs;
    logic  wr_en;

    assign wr_en = bus.seg_cs & bus.seg_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= REGS_RST;
        end else if (wr_en) begin
            case (bus.seg_addr)
                2'd0:    regs.data_lo <= bus.seg_wdata;
                2'd1:    regs.data_hi <= bus.seg_wdata;
                2'd2:    {regs.dp_mask, regs.en_mask} <= bus.seg_wdata;
                default: ;  // address 3 belongs to the optional blink register
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan divider and digit index
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       digit_idx;
    logic             slot_end;

    assign slot_end = (div_cnt == DIV_LAST);

    // The 3-bit index wraps 7 -> 0 by itself, so there is never an idle slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            digit_idx <= 3'd0;
        end else if (slot_end) begin
            div_cnt   <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            div_cnt   <= div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Optional blink: frame counter + blink mask
    // ------------------------------------------------------------------
    logic blink_blank;  // current digit must be hidden by the blink logic

`ifdef SEG7_BLINK_EN
    localparam int               FRM_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_DIV - 1);

    logic [7:0]       blink_mask;
    logic [FRM_W-1:0] frame_cnt;
    logic             blink_hidden;
    logic             frame_end;

    // A frame ends on the last divider cycle of digit 7.
    assign frame_end = slot_end & (digit_idx == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_mask <= 8'h00;
        end else if (wr_en && (bus.seg_addr == 2'd3)) begin
            blink_mask <= bus.seg_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt    <= '0;
                blink_hidden <= ~blink_hidden;
            end else begin
                frame_cnt    <= frame_cnt + 1'b1;
            end
        end
    end

    assign blink_blank = blink_hidden & blink_mask[digit_idx];
`else
    assign blink_blank = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Glyph decode (active low, dp bit left high here)
    // ------------------------------------------------------------------
    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0:    g = 8'hC0;
            4'h1:    g = 8'hF9;
            4'h2:    g = 8'hA4;
            4'h3:    g = 8'hB0;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h92;
            4'h6:    g = 8'h82;
            4'h7:    g = 8'hF8;
            4'h8:    g = 8'h80;
            4'h9:    g = 8'h90;
            4'hA:    g = 8'h88;
            4'hB:    g = 8'h83;
            4'hC:    g = 8'hC6;
            4'hD:    g = 8'hA1;
            4'hE:    g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Next output values for the current digit slot
    // ------------------------------------------------------------------
    logic [31:0] all_digits;
    logic [3:0]  nibble;
    logic        digit_vis;
    logic [7:0]  an_next;
    logic [7:0]  out_next;

    assign all_digits = {regs.data_hi, regs.data_lo};

    always_comb begin
        nibble    = all_digits[{digit_idx, 2'b00} +: 4];
        digit_vis = regs.en_mask[digit_idx] & ~blink_blank;
        an_next   = 8'hFF;
        out_next  = 8'hFF;
        // A blanked digit keeps its full slot with everything off, so the
        // duty cycle of the lit digits does not depend on the masks.
        if (digit_vis) begin
            an_next  = ~(8'h01 << digit_idx);
            out_next = hex_glyph(nibble) & {~regs.dp_mask[digit_idx], 7'h7F};
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_an  <= 8'hFF;
            seg_out <= 8'hFF;
        end else begin
            seg_an  <= an_next;
            seg_out <= out_next;
        end
    end

endmodule

// File: tb/tb_seg7_display.sv
// Self-checking bench for seg7_display with SCAN_DIV=4, BLINK_DIV=1.
// A cycle-count model predicts every registered output; directed vectors pin key values.
// Define SEG7_BLINK_EN for both bench and RTL to exercise the blink path.
module tb_seg7_display;

    localparam int SCAN = 4;
    localparam int BDIV = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seg_an;
    logic [7:0] seg_out;

    seg7_display_if bus ();

    seg7_display #(
        .SCAN_DIV  (SCAN),
        .BLINK_DIV (BDIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .seg_an  (seg_an),
        .seg_out (seg_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------------
    // Behavioural model: output after the k-th clock since reset release
    // (k counted from 0) shows digit (k / SCAN) % 8 of the register values
    // held before that edge; blink phase is frame number (k / (8*SCAN)).
    // ------------------------------------------------------------------
    logic [7:0]  glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int          k = 0;
    logic [15:0] m_lo = 16'h0;
    logic [15:0] m_hi = 16'h0;
    logic [7:0]  m_en = 8'hFF;
    logic [7:0]  m_dp = 8'h00;
    logic [7:0]  m_bl = 8'h00;
    logic [7:0]  exp_an  = 8'hFF;
    logic [7:0]  exp_out = 8'hFF;

    always @(posedge clk) begin
        int          d;
        logic [31:0] data;
        logic        hidden;
        if (rst) begin
            m_lo = 16'h0; m_hi = 16'h0; m_en = 8'hFF; m_dp = 8'h00; m_bl = 8'h00;
            k = 0;
            exp_an = 8'hFF; exp_out = 8'hFF;
        end else begin
            d      = (k / SCAN) % 8;
            data   = {m_hi, m_lo};
            hidden = (((k / (SCAN * 8)) / BDIV) % 2) == 1;
            if (m_en[d] && !(hidden && m_bl[d])) begin
                exp_an    = 8'hFF;
                exp_an[d] = 1'b0;
                exp_out   = glyph[data[d*4 +: 4]];
                if (m_dp[d]) exp_out[7] = 1'b0;
            end else begin
                exp_an  = 8'hFF;
                exp_out = 8'hFF;
            end
            if (bus.seg_cs && bus.seg_write) begin
                case (bus.seg_addr)
                    2'd0: m_lo = bus.seg_wdata;
                    2'd1: m_hi = bus.seg_wdata;
                    2'd2: {m_dp, m_en} = bus.seg_wdata;
                    default: begin
`ifdef SEG7_BLINK_EN
                        m_bl = bus.seg_wdata[7:0];
`endif
                    end
                endcase
            end
            k++;
        end
    end

    // Compare every cycle, sampled on the falling edge.
    always @(negedge clk) begin
        checks++;
        if (seg_an !== exp_an || seg_out !== exp_out) begin
            failures++;
            $display("FAIL model_cmp t=%0t seg_an=%h seg_out=%h, required seg_an=%h seg_out=%h",
                     $time, seg_an, seg_out, exp_an, exp_out);
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic lit(input string name, input logic [7:0] an, input logic [7:0] so);
        checks++;
        if (seg_an !== an || seg_out !== so) begin
            failures++;
            $display("FAIL %s: seg_an=%h seg_out=%h, required seg_an=%h seg_out=%h",
                     name, seg_an, seg_out, an, so);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic cs, input logic we);
        bus.seg_addr  = a;
        bus.seg_wdata = d;
        bus.seg_cs    = cs;
        bus.seg_write = we;
        @(negedge clk);
        bus.seg_cs    = 1'b0;
        bus.seg_write = 1'b0;
    endtask

    // Advance to the first cycle of the next slot showing digit d.
    task automatic goto(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((((k - 1) / SCAN) % 8 == d) && ((k - 1) % SCAN == 0)) && n < 100);
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL goto_timeout: digit %0d not reached within 100 cycles", d);
        end
    endtask

    logic [7:0] an_seq [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] a0, o0, a1, o1, want_an;

    initial begin
        bus.seg_cs    = 1'b0;
        bus.seg_write = 1'b0;
        bus.seg_addr  = 2'd0;
        bus.seg_wdata = 16'h0000;

        // Reset held for three cycles, then the first output is digit 0.
        repeat (3) @(negedge clk);
        lit("reset_hold", 8'hFF, 8'hFF);
        rst = 1'b0;
        @(negedge clk);
        lit("first_after_reset", 8'hFE, 8'hC0);

        // Data write.
        wr(2'd0, 16'h1234, 1'b1, 1'b1);
        goto(1); lit("write_d1", 8'hFD, 8'hB0);
        goto(0); lit("write_d0", 8'hFE, 8'h99);

        // Scan wrap: 32 cycles plus the return to digit 0.
        for (int i = 0; i < 33; i++) begin
            want_an = an_seq[(i / SCAN) % 8];
            checks++;
            if (seg_an !== want_an) begin
                failures++;
                $display("FAIL scan_wrap[%0d]: seg_an=%h, required %h", i, seg_an, want_an);
            end
            @(negedge clk);
        end
        goto(3); lit("scan_d3", 8'hF7, 8'hF9);
        goto(4); lit("scan_d4", 8'hEF, 8'hC0);

        // Gated writes leave the display alone.
        wr(2'd0, 16'hFFFF, 1'b0, 1'b1);
        wr(2'd0, 16'hFFFF, 1'b1, 1'b0);
        goto(0); lit("gated_d0", 8'hFE, 8'h99);
        goto(1); lit("gated_d1", 8'hFD, 8'hB0);

        // Write on the final divider cycle of digit 0.
        goto(0);
        @(negedge clk);
        @(negedge clk);
        wr(2'd0, 16'h1254, 1'b1, 1'b1);
        lit("last_cycle_d0", 8'hFE, 8'h99);
        @(negedge clk);
        lit("last_cycle_new_d1", 8'hFD, 8'h92);

        // Enable and dp masks.
        wr(2'd0, 16'h1234, 1'b1, 1'b1);
        wr(2'd2, 16'h0101, 1'b1, 1'b1);
        goto(0); lit("mask_d0_dp", 8'hFE, 8'h19);
        goto(1); lit("mask_d1_off", 8'hFF, 8'hFF);
        goto(6); lit("mask_d6_off", 8'hFF, 8'hFF);
        goto(7); lit("mask_d7_off", 8'hFF, 8'hFF);
        wr(2'd2, 16'h00FF, 1'b1, 1'b1);

        // Blink mask on digit 0 over two consecutive frames.
        wr(2'd3, 16'h0001, 1'b1, 1'b1);
        goto(0); a0 = seg_an; o0 = seg_out;
        goto(1); lit("blink_d1_a", 8'hFD, 8'hB0);
        goto(0); a1 = seg_an; o1 = seg_out;
        goto(1); lit("blink_d1_b", 8'hFD, 8'hB0);
`ifdef SEG7_BLINK_EN
        checks++;
        if (!((a0 == 8'hFE && o0 == 8'h99 && a1 == 8'hFF && o1 == 8'hFF) ||
              (a0 == 8'hFF && o0 == 8'hFF && a1 == 8'hFE && o1 == 8'h99))) begin
            failures++;
            $display("FAIL blink_alternate: frames %h/%h then %h/%h, required FE/99 and FF/FF alternating",
                     a0, o0, a1, o1);
        end
`else
        checks++;
        if (a0 !== 8'hFE || o0 !== 8'h99 || a1 !== 8'hFE || o1 !== 8'h99) begin
            failures++;
            $display("FAIL no_blink: frames %h/%h then %h/%h, required FE/99 both", a0, o0, a1, o1);
        end
`endif

        // Reset mid-scan with a simultaneous write: reset wins.
        goto(3);
        rst           = 1'b1;
        bus.seg_addr  = 2'd0;
        bus.seg_wdata = 16'hFFFF;
        bus.seg_cs    = 1'b1;
        bus.seg_write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        lit("rst_mid_scan", 8'hFF, 8'hFF);
        rst           = 1'b0;
        bus.seg_cs    = 1'b0;
        bus.seg_write = 1'b0;
        @(negedge clk);
        lit("restart_d0", 8'hFE, 8'hC0);
        goto(2); lit("after_rst_d2", 8'hFB, 8'hC0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
